// File: rtl/filter_mc_pkg.sv
// Shared constants, state types and elaboration helpers for the filter_mc
// multi-channel complex FIR and its tap loader.
package filter_mc_pkg;

    localparam int ERR_DROP   = 0;
    localparam int ERR_BADCH  = 1;
    localparam int ERR_OVF    = 2;
    localparam int ERR_TAPSET = 3;
    localparam int NERR       = 4;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_PEND
    } ld_state_e;

    typedef enum logic [1:0] {
        MAC_IDLE,
        MAC_RUN,
        MAC_OUT
    } mac_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Message words carry one extra bit above the sample width: the header flag.
    function automatic int msg_width(input int width);
        return width + 1;
    endfunction

    function automatic int hdr_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/filter_tap_loader.sv
// Message-chain tap loader: parses headers, fills the shadow tap bank and
// swaps banks when the MAC allows; unconsumed words are forwarded one cycle later.
module filter_tap_loader
    import filter_mc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FLTLEN = 10,
    parameter int ID     = 0,
    localparam int HW        = WIDTH / 2,
    localparam int MSG_WIDTH = msg_width(WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MSG_WIDTH-1:0]           msg_i,
    input  logic                           msg_nd_i,
    output logic [MSG_WIDTH-1:0]           msg_o,
    output logic                           msg_nd_o,
    output logic [FLTLEN-1:0][HW-1:0]      taps_o,
    output logic                           swap_req_o,
    input  logic                           swap_ok_i,
    output logic                           tapset_err_o
);

    localparam int LOG_FLTLEN = clog2(FLTLEN);
    localparam int HDR        = hdr_bit(WIDTH);

    ld_state_e                      state_q, state_d;
    logic [LOG_FLTLEN-1:0]          idx_q, idx_d;
    logic                           active_q, active_d;
    logic [1:0][FLTLEN-1:0][HW-1:0] bank_q;
    logic [MSG_WIDTH-1:0]           msg_q;
    logic                           msg_nd_q;
    logic                           wr_en;
    logic                           fwd;
    logic                           is_hdr;
    logic                           id_match;

    assign is_hdr     = msg_i[HDR];
    assign id_match   = (msg_i[WIDTH-1:0] == WIDTH'(ID));
    assign taps_o     = bank_q[active_q];
    assign swap_req_o = (state_q == LD_PEND);
    assign msg_o      = msg_q;
    assign msg_nd_o   = msg_nd_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        active_d     = active_q;
        wr_en        = 1'b0;
        fwd          = 1'b0;
        tapset_err_o = 1'b0;
        if (state_q == LD_PEND && swap_ok_i) begin
            active_d = ~active_q;
            state_d  = LD_IDLE;
        end
        if (msg_nd_i) begin
            case (state_q)
                LD_LOAD: begin
                    if (is_hdr) begin
                        tapset_err_o = 1'b1;
                        idx_d        = '0;
                    end else begin
                        wr_en = 1'b1;
                        if (idx_q == LOG_FLTLEN'(FLTLEN - 1)) begin
                            state_d = LD_PEND;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // A fresh header for us supersedes any pending swap.
                    if (is_hdr && id_match) begin
                        state_d  = LD_LOAD;
                        idx_d    = '0;
                        active_d = active_q;
                    end else begin
                        fwd = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LD_IDLE;
            idx_q    <= '0;
            active_q <= 1'b0;
            bank_q   <= '0;
            msg_q    <= '0;
            msg_nd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            msg_q    <= msg_i;
            msg_nd_q <= fwd;
            if (wr_en) begin
                bank_q[~active_q][idx_q] <= msg_i[HW-1:0];
            end
        end
    end

endmodule

// File: rtl/filter_mc.sv
// Time-multiplexed complex FIR: per-channel sample histories, one shared real
// tap set, and a sequential MAC that produces one output per accepted sample.
module filter_mc
    import filter_mc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1,
    parameter int FLTLEN = 10,
    parameter int NCHAN  = 4,
    parameter int SHIFT  = 15,
    parameter int ID     = 0,
    localparam int LOG_NCHAN = (clog2(NCHAN) > 1) ? clog2(NCHAN) : 1,
    localparam int MSG_WIDTH = msg_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_nd,
    input  logic [LOG_NCHAN-1:0] in_ch,
    input  logic [MWIDTH-1:0]    in_m,
    output logic                 in_ready,
    input  logic [MSG_WIDTH-1:0] in_msg,
    input  logic                 in_msg_nd,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_nd,
    output logic [LOG_NCHAN-1:0] out_ch,
    output logic [MWIDTH-1:0]    out_m,
    output logic [MSG_WIDTH-1:0] out_msg,
    output logic                 out_msg_nd,
    output logic                 error
);

    localparam int HW         = WIDTH / 2;
    localparam int LOG_FLTLEN = clog2(FLTLEN);
    localparam int AW         = WIDTH + LOG_FLTLEN;

    mac_state_e                         state_q, state_d;
    logic [LOG_FLTLEN-1:0]              k_q, k_d;
    logic [LOG_NCHAN-1:0]               ch_q;
    logic [MWIDTH-1:0]                  m_q;
    logic signed [AW-1:0]               acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [NCHAN-1:0][FLTLEN-1:0][WIDTH-1:0] hist_q;
    logic [NERR-1:0]                    err_q, err_d;
    logic [WIDTH-1:0]                   out_data_q;
    logic                               out_nd_q;
    logic [LOG_NCHAN-1:0]               out_ch_q;
    logic [MWIDTH-1:0]                  out_m_q;

    logic [FLTLEN-1:0][HW-1:0]          taps;
    logic                               swap_req, swap_ok, tapset_err;
    logic [LOG_NCHAN:0]                 ch_ext;
    logic                               ch_ok, accept;
    logic [WIDTH-1:0]                   x;
    logic signed [HW-1:0]               x_re, x_im, tap;
    logic signed [WIDTH-1:0]            prod_re, prod_im;
    logic signed [AW-1:0]               sh_re, sh_im;
    logic                               ovf_re, ovf_im;
    logic [HW-1:0]                      sat_re, sat_im;

    filter_tap_loader #(
        .WIDTH  (WIDTH),
        .FLTLEN (FLTLEN),
        .ID     (ID)
    ) u_loader (
        .clk          (clk),
        .rst          (rst),
        .msg_i        (in_msg),
        .msg_nd_i     (in_msg_nd),
        .msg_o        (out_msg),
        .msg_nd_o     (out_msg_nd),
        .taps_o       (taps),
        .swap_req_o   (swap_req),
        .swap_ok_i    (swap_ok),
        .tapset_err_o (tapset_err)
    );

    assign in_ready = (state_q == MAC_IDLE);
    assign ch_ext   = {1'b0, in_ch};
    assign ch_ok    = (ch_ext < (LOG_NCHAN + 1)'(NCHAN));
    assign accept   = in_nd && in_ready && ch_ok;
    // Taps only change while the MAC is idle, so a running MAC keeps its bank.
    assign swap_ok  = swap_req && (state_q == MAC_IDLE) && !accept;

    assign x       = hist_q[ch_q][k_q];
    assign x_re    = x[WIDTH-1:HW];
    assign x_im    = x[HW-1:0];
    assign tap     = taps[k_q];
    assign prod_re = x_re * tap;
    assign prod_im = x_im * tap;

    assign sh_re  = acc_re_q >>> SHIFT;
    assign sh_im  = acc_im_q >>> SHIFT;
    assign ovf_re = !((&sh_re[AW-1:HW-1]) || !(|sh_re[AW-1:HW-1]));
    assign ovf_im = !((&sh_im[AW-1:HW-1]) || !(|sh_im[AW-1:HW-1]));
    assign sat_re = ovf_re ? {sh_re[AW-1], {(HW-1){~sh_re[AW-1]}}} : sh_re[HW-1:0];
    assign sat_im = ovf_im ? {sh_im[AW-1], {(HW-1){~sh_im[AW-1]}}} : sh_im[HW-1:0];

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        case (state_q)
            MAC_IDLE: begin
                if (accept) begin
                    state_d  = MAC_RUN;
                    k_d      = '0;
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
            end
            MAC_RUN: begin
                acc_re_d = acc_re_q + AW'(prod_re);
                acc_im_d = acc_im_q + AW'(prod_im);
                if (k_q == LOG_FLTLEN'(FLTLEN - 1)) begin
                    state_d = MAC_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = MAC_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (in_nd && !in_ready) err_d[ERR_DROP] = 1'b1;
        if (in_nd && !ch_ok) err_d[ERR_BADCH] = 1'b1;
        if (state_q == MAC_OUT && (ovf_re || ovf_im)) err_d[ERR_OVF] = 1'b1;
        if (tapset_err) err_d[ERR_TAPSET] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MAC_IDLE;
            k_q        <= '0;
            ch_q       <= '0;
            m_q        <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            hist_q     <= '0;
            err_q      <= '0;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
            out_ch_q   <= '0;
            out_m_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            err_q    <= err_d;
            out_nd_q <= (state_q == MAC_OUT);
            if (accept) begin
                ch_q          <= in_ch;
                m_q           <= in_m;
                hist_q[in_ch] <= {hist_q[in_ch][FLTLEN-2:0], in_data};
            end
            if (state_q == MAC_OUT) begin
                out_data_q <= {sat_re, sat_im};
                out_ch_q   <= ch_q;
                out_m_q    <= m_q;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign out_ch   = out_ch_q;
    assign out_m    = out_m_q;
    assign error    = |err_q;

endmodule

// File: tb/tb_filter_mc.sv
// Directed bench for filter_mc: a cycle-level reference model of the filter and
// tap loader, an every-cycle compare process, and literal output expectations.
module tb_filter_mc;

    localparam int WIDTH     = 32;
    localparam int MWIDTH    = 1;
    localparam int FLTLEN    = 4;
    localparam int NCHAN     = 2;
    localparam int SHIFT     = 15;
    localparam int ID        = 3;
    localparam int HW        = WIDTH / 2;
    localparam int LOG_NCHAN = 1;
    localparam int MSG_WIDTH = WIDTH + 1;
    localparam int NLIT      = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_nd = 1'b0;
    logic [LOG_NCHAN-1:0] in_ch = '0;
    logic [MWIDTH-1:0]    in_m = '0;
    logic                 in_ready;
    logic [MSG_WIDTH-1:0] in_msg = '0;
    logic                 in_msg_nd = 1'b0;
    logic [WIDTH-1:0]     out_data;
    logic                 out_nd;
    logic [LOG_NCHAN-1:0] out_ch;
    logic [MWIDTH-1:0]    out_m;
    logic [MSG_WIDTH-1:0] out_msg;
    logic                 out_msg_nd;
    logic                 error;

    always #5 clk = ~clk;

    filter_mc #(
        .WIDTH  (WIDTH),
        .MWIDTH (MWIDTH),
        .FLTLEN (FLTLEN),
        .NCHAN  (NCHAN),
        .SHIFT  (SHIFT),
        .ID     (ID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_nd      (in_nd),
        .in_ch      (in_ch),
        .in_m       (in_m),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .in_msg_nd  (in_msg_nd),
        .out_data   (out_data),
        .out_nd     (out_nd),
        .out_ch     (out_ch),
        .out_m      (out_m),
        .out_msg    (out_msg),
        .out_msg_nd (out_msg_nd),
        .error      (error)
    );

    // ---------------- reference model ----------------
    typedef struct {
        longint due;
        int     ch;
        int     m;
        int     re;
        int     im;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   exp_now;
    longint cyc = 0;
    longint m_free = 0;
    int     hist_re[NCHAN][FLTLEN];
    int     hist_im[NCHAN][FLTLEN];
    int     act_tap[FLTLEN];
    int     shd_tap[FLTLEN];
    int     ld_mode = 0;   // 0 idle, 1 loading, 2 waiting to swap
    int     ld_idx = 0;
    bit     model_on = 0;
    bit     exp_nd = 0;
    bit     exp_ready = 1;
    bit     exp_err = 0;
    bit     exp_msg_nd = 0;
    logic [MSG_WIDTH-1:0] exp_msg = '0;

    function automatic int sat16(input longint v, inout bit ovf);
        if (v > 32767) begin ovf = 1; return 32767; end
        if (v < -32768) begin ovf = 1; return -32768; end
        return int'(v);
    endfunction

    always @(posedge clk) begin
        bit     idle, acc, do_swap, nxt_fwd, ovf;
        longint sre, sim;
        int     ich, tmp;
        exp_t   e;
        model_on = 1;
        nxt_fwd = 0;
        if (rst) begin
            exp_q.delete();
            m_free = 0;
            ld_mode = 0;
            ld_idx = 0;
            exp_err = 0;
            for (int c = 0; c < NCHAN; c++)
                for (int k = 0; k < FLTLEN; k++) begin
                    hist_re[c][k] = 0;
                    hist_im[c][k] = 0;
                end
            for (int k = 0; k < FLTLEN; k++) begin
                act_tap[k] = 0;
                shd_tap[k] = 0;
            end
        end else begin
            ich = int'(in_ch);
            idle = (cyc >= m_free);
            acc = in_nd && idle && (ich < NCHAN);
            if (in_nd && !idle) exp_err = 1;
            if (in_nd && ich >= NCHAN) exp_err = 1;
            do_swap = (ld_mode == 2) && idle && !acc;
            if (in_msg_nd) begin
                if (ld_mode == 1) begin
                    if (in_msg[WIDTH]) begin
                        exp_err = 1;
                        ld_idx = 0;
                    end else begin
                        shd_tap[ld_idx] = int'($signed(in_msg[HW-1:0]));
                        ld_idx++;
                        if (ld_idx == FLTLEN) ld_mode = 2;
                    end
                end else if (in_msg[WIDTH] && in_msg[WIDTH-1:0] == WIDTH'(ID)) begin
                    ld_mode = 1;
                    ld_idx = 0;
                    do_swap = 0;
                end else begin
                    nxt_fwd = 1;
                    exp_msg = in_msg;
                end
            end
            if (do_swap) begin
                for (int k = 0; k < FLTLEN; k++) begin
                    tmp = act_tap[k];
                    act_tap[k] = shd_tap[k];
                    shd_tap[k] = tmp;
                end
                ld_mode = 0;
            end
            if (acc) begin
                for (int k = FLTLEN - 1; k > 0; k--) begin
                    hist_re[ich][k] = hist_re[ich][k-1];
                    hist_im[ich][k] = hist_im[ich][k-1];
                end
                hist_re[ich][0] = int'($signed(in_data[WIDTH-1:HW]));
                hist_im[ich][0] = int'($signed(in_data[HW-1:0]));
                sre = 0;
                sim = 0;
                for (int k = 0; k < FLTLEN; k++) begin
                    sre += longint'(hist_re[ich][k]) * longint'(act_tap[k]);
                    sim += longint'(hist_im[ich][k]) * longint'(act_tap[k]);
                end
                ovf = 0;
                e.re = sat16(sre >>> SHIFT, ovf);
                e.im = sat16(sim >>> SHIFT, ovf);
                e.ovf = ovf;
                e.due = cyc + FLTLEN + 2;
                e.ch = ich;
                e.m = int'(in_m);
                exp_q.push_back(e);
                m_free = cyc + FLTLEN + 2;
            end
        end
        cyc++;
        exp_ready = (cyc >= m_free);
        exp_msg_nd = nxt_fwd;
        exp_nd = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_now = exp_q.pop_front();
            exp_nd = 1;
            if (exp_now.ovf) exp_err = 1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    bit fin_req = 0;
    bit fin_done = 0;
    int lit_ch[NLIT] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    int lit_re[NLIT] = '{500, 50, 100, 100, 200, 600, 300, 50, 32767, -32367, 0, 500};
    int lit_im[NLIT] = '{-1000, -50, 0, -100, 0, -100, 100, 0, 32767, -32767, 0, 0};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        int a_re, a_im;
        if (model_on) begin
            a_re = int'($signed(out_data[WIDTH-1:HW]));
            a_im = int'($signed(out_data[HW-1:0]));
            chk("in_ready", longint'(in_ready), longint'(exp_ready));
            chk("out_nd", longint'(out_nd), longint'(exp_nd));
            chk("error", longint'(error), longint'(exp_err));
            chk("out_msg_nd", longint'(out_msg_nd), longint'(exp_msg_nd));
            if (exp_msg_nd) chk("out_msg", longint'(out_msg), longint'(exp_msg));
            if (exp_nd) begin
                chk("out_ch", longint'(out_ch), longint'(exp_now.ch));
                chk("out_m", longint'(out_m), longint'(exp_now.m));
                chk("out_re", longint'(a_re), longint'(exp_now.re));
                chk("out_im", longint'(a_im), longint'(exp_now.im));
            end
            if (out_nd) begin
                if (out_cnt < NLIT) begin
                    chk("lit_ch", longint'(out_ch), longint'(lit_ch[out_cnt]));
                    chk("lit_re", longint'(a_re), longint'(lit_re[out_cnt]));
                    chk("lit_im", longint'(a_im), longint'(lit_im[out_cnt]));
                end
                out_cnt++;
            end
            if (fin_req && !fin_done) begin
                chk("output_count", longint'(out_cnt), longint'(NLIT));
                fin_done = 1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic send_msg(input logic [MSG_WIDTH-1:0] w);
        in_msg = w;
        in_msg_nd = 1'b1;
        tick();
        in_msg_nd = 1'b0;
        in_msg = '0;
    endtask

    task automatic send_hdr(input int dest);
        logic [WIDTH-1:0] d;
        d = WIDTH'(dest);
        send_msg({1'b1, d});
    endtask

    task automatic send_tap(input int t);
        logic [HW-1:0] v;
        v = HW'(t);
        send_msg({1'b0, {HW{1'b0}}, v});
    endtask

    task automatic load_taps(input int t0, input int t1, input int t2, input int t3);
        send_hdr(ID);
        send_tap(t0);
        send_tap(t1);
        send_tap(t2);
        send_tap(t3);
    endtask

    task automatic send_sample(input int ch, input int re, input int im, input int m);
        logic [HW-1:0] r, i;
        r = HW'(re);
        i = HW'(im);
        in_data = {r, i};
        in_ch = LOG_NCHAN'(ch);
        in_m = MWIDTH'(m);
        in_nd = 1'b1;
        tick();
        in_nd = 1'b0;
    endtask

    initial begin
        do_reset();
        // single tap of 0.5
        load_taps(16384, 0, 0, 0);
        idle(2);
        send_sample(0, 1000, -2000, 1);
        idle(8);
        // interleaved channels, back-to-back accept on the out_nd cycle
        do_reset();
        load_taps(16384, 16384, 16384, 16384);
        idle(2);
        send_sample(0, 100, -100, 0);
        idle(5);
        send_sample(1, 200, 0, 1);
        idle(5);
        send_sample(0, 100, -100, 1);
        idle(6);
        // traffic for another ID is forwarded untouched
        send_hdr(5);
        send_tap(32'h1234);
        send_tap(32'hABCD);
        idle(1);
        send_sample(1, 200, 0, 0);
        idle(6);
        // load during a running MAC
        send_sample(0, 1000, 0, 1);
        load_taps(8192, 8192, 0, 0);
        idle(3);
        send_sample(0, 200, 400, 0);
        idle(6);
        // drop while busy, then saturation and negative floor
        send_sample(1, 1, 0, 1);
        send_sample(0, 5, 5, 0);
        idle(5);
        load_taps(32767, 32767, 32767, 32767);
        idle(2);
        send_sample(0, 32767, 32767, 1);
        idle(6);
        send_sample(1, -32768, -32768, 0);
        idle(6);
        // reset in the middle of a load
        do_reset();
        send_hdr(ID);
        send_tap(16384);
        send_tap(16384);
        do_reset();
        send_sample(0, 1000, 1000, 0);
        idle(6);
        // header during a load restarts it
        send_hdr(ID);
        send_tap(777);
        send_hdr(ID);
        send_tap(16384);
        send_tap(0);
        send_tap(0);
        send_tap(0);
        idle(2);
        send_sample(0, 1000, 0, 1);
        idle(6);
        fin_req = 1;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
